branch_step_sequencer: RTL and testbench

//  Step-control FSM for the conditional-branch datapath built around the CON FF logic.
//  - Fetch steps: sequences PC/MAR/MDR/IR loads and waits on memory.
//  - Branch steps: drives Gra/Rout/CONin so the CON FF evaluates the IR condition against the bus.
//  - Redirect: computes PC+C, then loads PC only if the latched CON is high; counts taken branches.

---
 rtl/branch_step_sequencer_if.sv | 49 ++++
 rtl/branch_step_sequencer.sv | 134 +++++++++++++
 tb/tb_branch_step_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/branch_step_sequencer_if.sv
// Handshake/strobe bundle between the branch step sequencer and its datapath.
// master = sequencer side (drives strobes/status), slave = datapath/environment side.
// Carries the start request, IR/CON/memory status inputs and all step strobes.
interface branch_step_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      ir_q;
  logic             con_q;
  logic             mem_ready;

  logic             pc_out;
  logic             mar_in;
  logic             inc_pc;
  logic             z_in;
  logic             zlow_out;
  logic             pc_in;
  logic             mem_read;
  logic             mdr_in;
  logic             mdr_out;
  logic             ir_load;
  logic             gra;
  logic             r_out;
  logic             con_in;
  logic             y_in;
  logic             c_out;
  logic             alu_add;

  logic             busy;
  logic             done;
  logic             illegal_op;
  logic             mem_err;
  logic [CNT_W-1:0] taken_cnt;
  logic [3:0]       step;

  modport master (
    input  start, ir_q, con_q, mem_ready,
    output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in,
           mdr_out, ir_load, gra, r_out, con_in, y_in, c_out, alu_add,
           busy, done, illegal_op, mem_err, taken_cnt, step
  );

  modport slave (
    output start, ir_q, con_q, mem_ready,
    input  pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in,
           mdr_out, ir_load, gra, r_out, con_in, y_in, c_out, alu_add,
           busy, done, illegal_op, mem_err, taken_cnt, step
  );
endinterface

// File: rtl/branch_step_sequencer.sv
// Step-control FSM for fetch + conditional branch around the CON FF datapath.
// Latency: start -> done 8 cycles with memory ready; each extra T1 wait adds one.
// Waits in T1 on mem_ready with a bounded timeout; start ignored while busy.
module branch_step_sequencer #(
  parameter logic [4:0] BR_OPCODE   = 5'b10010,
  parameter int         MEM_TIMEOUT = 15,
  parameter int         CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  branch_step_sequencer_if.master      bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only the opcode field of the IR matters to this sequencer.
  logic unused_ir;
  assign unused_ir = ^bus.ir_q[26:0];

  // Next-state, timeout, sticky-flag and taken-counter computation.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_T0;
          illegal_d = 1'b0;
          mem_err_d = 1'b0;
        end
      end
      S_T0: begin
        state_d = S_T1;
        tmo_d   = 8'd0;
      end
      S_T1: begin
        if (bus.mem_ready) begin
          state_d = S_T2;
        end else if (tmo_q == 8'(MEM_TIMEOUT - 1)) begin
          // Final wait cycle exhausted: abandon the instruction without done.
          state_d   = S_IDLE;
          mem_err_d = 1'b1;
          tmo_d     = 8'd0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (bus.ir_q[31:27] != BR_OPCODE) begin
          // PC was already incremented in T0/T1, so just finish.
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = S_T6;
      S_T6: begin
        if (bus.con_q && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and status registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= 8'd0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobe decode of the registered state; only pc_in in T6 looks at an input.
  always_comb begin
    bus.pc_out   = (state_q == S_T0) || (state_q == S_T4);
    bus.mar_in   = (state_q == S_T0);
    bus.inc_pc   = (state_q == S_T0);
    bus.z_in     = (state_q == S_T0) || (state_q == S_T5);
    bus.zlow_out = (state_q == S_T1) || (state_q == S_T6);
    bus.pc_in    = (state_q == S_T1) || ((state_q == S_T6) && bus.con_q);
    bus.mem_read = (state_q == S_T1);
    bus.mdr_in   = (state_q == S_T1);
    bus.mdr_out  = (state_q == S_T2);
    bus.ir_load  = (state_q == S_T2);
    bus.gra      = (state_q == S_T3);
    bus.r_out    = (state_q == S_T3);
    bus.con_in   = (state_q == S_T3);
    bus.y_in     = (state_q == S_T4);
    bus.c_out    = (state_q == S_T5);
    bus.alu_add  = (state_q == S_T5);
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
  end

  assign bus.illegal_op = illegal_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.taken_cnt  = cnt_q;
  assign bus.step       = state_q;

endmodule

// File: tb/tb_branch_step_sequencer.sv
// Bench for branch_step_sequencer: table of instructions with expected outcomes,
// a cycle-by-cycle step model for strobes, and a hand-written reset-abort sequence.
module tb_branch_step_sequencer;

  localparam logic [4:0] BR = 5'b10010;
  localparam int         CW = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  branch_step_sequencer_if #(.CNT_W(CW)) bus ();

  branch_step_sequencer #(
    .BR_OPCODE  (BR),
    .MEM_TIMEOUT(15),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         wait_n;   // T1 cycles with mem_ready low before it rises
    logic [4:0] opc;
    logic       con;
    logic       poke;     // pulse start while busy (must be ignored)
    int         exp_lat;  // cycle of done pulse after start cycle, 0 = none
    logic       exp_ill;
    logic       exp_merr;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit order: pc_out mar_in inc_pc z_in zlow_out pc_in mem_read mdr_in
  //            mdr_out ir_load gra r_out con_in y_in c_out alu_add
  function automatic logic [15:0] get_strb();
    return {bus.pc_out, bus.mar_in, bus.inc_pc, bus.z_in, bus.zlow_out, bus.pc_in,
            bus.mem_read, bus.mdr_in, bus.mdr_out, bus.ir_load, bus.gra, bus.r_out,
            bus.con_in, bus.y_in, bus.c_out, bus.alu_add};
  endfunction

  function automatic logic [15:0] exp_strb(input int st, input logic con);
    case (st)
      1:       return 16'hF000;
      2:       return 16'h0F00;
      3:       return 16'h00C0;
      4:       return 16'h0038;
      5:       return 16'h8004;
      6:       return 16'h1003;
      7:       return con ? 16'h0C00 : 16'h0800;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    int   t1n;
    int   est;
    int   nxt;
    int   dut_done;
    vec_t e;
    bus.ir_q      = {v.opc, 27'h0};
    bus.con_q     = v.con;
    bus.mem_ready = 1'b0;
    bus.start     = 1'b1;
    sb.push_back(v);
    cyc      = 0;
    t1n      = 0;
    est      = 1;
    dut_done = 0;
    while (est != 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (v.poke && (cyc == 3 || est == 8)) bus.start = 1'b1;
      chk($sformatf("v%0d step c%0d", idx, cyc), 32'(bus.step), 32'(est));
      chk($sformatf("v%0d strobes c%0d", idx, cyc), 32'(get_strb()), 32'(exp_strb(est, v.con)));
      chk($sformatf("v%0d busy c%0d", idx, cyc), 32'(bus.busy), 32'(est != 0));
      if (bus.done) dut_done = cyc;
      if (est == 8) chk($sformatf("v%0d illegal_in_done", idx), 32'(bus.illegal_op), 32'(v.exp_ill));
      bus.mem_ready = 1'b0;
      case (est)
        1: nxt = 2;
        2: begin
          t1n++;
          bus.mem_ready = (t1n > v.wait_n);
          nxt = bus.mem_ready ? 3 : ((t1n == 15) ? 0 : 2);
        end
        3: nxt = 4;
        4: nxt = (v.opc == BR) ? 5 : 8;
        5: nxt = 6;
        6: nxt = 7;
        7: nxt = 8;
        default: nxt = 0;
      endcase
      est = nxt;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk($sformatf("v%0d idle_end", idx), 32'(bus.step), 32'd0);
    if (bus.done) dut_done = cyc + 1;
    e = sb.pop_front();
    chk($sformatf("v%0d done_latency", idx), 32'(dut_done), 32'(e.exp_lat));
    chk($sformatf("v%0d illegal_op", idx), 32'(bus.illegal_op), 32'(e.exp_ill));
    chk($sformatf("v%0d mem_err", idx), 32'(bus.mem_err), 32'(e.exp_merr));
    chk($sformatf("v%0d taken_cnt", idx), 32'(bus.taken_cnt), 32'(e.exp_cnt));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    bus.start     = 1'b0;
    bus.ir_q      = 32'h0;
    bus.con_q     = 1'b0;
    bus.mem_ready = 1'b0;

    //            wait opc       con  poke lat ill  merr cnt
    vecs[0] = '{0,   BR,       1'b1, 1'b0, 8,  1'b0, 1'b0, 2'd1};
    vecs[1] = '{0,   BR,       1'b0, 1'b0, 8,  1'b0, 1'b0, 2'd1};
    vecs[2] = '{0,   5'b00011, 1'b1, 1'b0, 5,  1'b1, 1'b0, 2'd1};
    vecs[3] = '{3,   BR,       1'b1, 1'b0, 11, 1'b0, 1'b0, 2'd2};
    vecs[4] = '{100, BR,       1'b1, 1'b0, 0,  1'b0, 1'b1, 2'd2};
    vecs[5] = '{0,   BR,       1'b1, 1'b0, 8,  1'b0, 1'b0, 2'd3};
    vecs[6] = '{1,   BR,       1'b1, 1'b1, 9,  1'b0, 1'b0, 2'd3};
    vecs[7] = '{0,   BR,       1'b1, 1'b0, 8,  1'b0, 1'b0, 2'd3};

    #1 reset = 1'b1;
    #2;
    chk("rst step", 32'(bus.step), 32'd0);
    chk("rst strobes", 32'(get_strb()), 32'd0);
    chk("rst busy_done", 32'({bus.busy, bus.done}), 32'd0);
    chk("rst flags", 32'({bus.illegal_op, bus.mem_err}), 32'd0);
    chk("rst taken_cnt", 32'(bus.taken_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset arriving while the branch is in T4 aborts with no done pulse.
    bus.ir_q      = {BR, 27'h0};
    bus.con_q     = 1'b1;
    bus.mem_ready = 1'b1;
    bus.start     = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("pre_reset step_T4", 32'(bus.step), 32'd5);
    reset = 1'b1;
    #1;
    chk("async_rst step", 32'(bus.step), 32'd0);
    chk("async_rst strobes", 32'(get_strb()), 32'd0);
    chk("async_rst busy_done", 32'({bus.busy, bus.done}), 32'd0);
    chk("async_rst taken_cnt", 32'(bus.taken_cnt), 32'd0);
    @(posedge clk); #1;
    chk("rst_edge step", 32'(bus.step), 32'd0);
    chk("rst_edge done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst idle", 32'({bus.step, bus.busy, bus.done}), 32'd0);
    chk("post_rst taken_cnt", 32'(bus.taken_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
